// File: rtl/rvi_lsu.sv
// rvi_lsu: load/store unit for the RVI MEM stage.
// Turns one load/store per instruction into a request/acknowledge bus
// transaction with byte-lane steering, load extension and fault detection.
// Optional feature macro: LSU_TIMEOUT_EN (bounds BUSY to TIMEOUT cycles).
//
// Ports:
//   CLK, RESET_N            clock (rising edge), async active-low reset
//   req_valid/req_write     MEM-stage load/store request, 1 = store
//   req_funct3/req_addr     RISC-V size/sign code and byte address
//   req_wdata               store data (rs2)
//   stall                   freeze pipeline while the access is in flight
//   rsp_valid/rsp_rdata     one-cycle completion pulse with extended load data
//   fault                   misaligned / illegal / timed-out access
//   mem_req/mem_we/mem_be   bus request, write enable, byte enables
//   mem_addr/mem_wdata      word-aligned address, lane-replicated store data
//   mem_ack/mem_rdata       bus completion and read data (same cycle)
module rvi_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  if ((XLEN != 32 && XLEN != 64) || TIMEOUT < 1) begin : g_param_check
    $error("rvi_lsu: XLEN must be 32 or 64 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic is_legal(logic wr, logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b011:                 return (XLEN == 64);
      3'b100, 3'b101:         return !wr;
      3'b110:                 return (XLEN == 64) && !wr;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [NB-1:0] lane_mask(logic [1:0] sz, logic [OFFW-1:0] off);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[i] = (i < (1 << sz));
    return m << off;
  endfunction

  // Store data is copied into every lane so the bus only needs mem_be.
  function automatic logic [XLEN-1:0] replicate(logic [XLEN-1:0] d, logic [1:0] sz);
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = d[8*(i & ((1 << sz) - 1)) +: 8];
    return r;
  endfunction

  // d already has the addressed bytes shifted down to lane 0.
  function automatic logic [XLEN-1:0] extend(logic [XLEN-1:0] d, logic [2:0] f3);
    logic [XLEN-1:0] r;
    int              top;
    logic            sbit;
    top = 8 << f3[1:0];
    if (top > XLEN) top = XLEN;
    sbit = ~f3[2] & d[top-1];
    for (int i = 0; i < XLEN; i++) r[i] = (i < top) ? d[i] : sbit;
    return r;
  endfunction

  state_t          state;
  logic [2:0]      f3_p0;
  logic [OFFW-1:0] off_p0;
  logic            bad_req;
  logic [XLEN-1:0] lane_data;

  assign bad_req = !is_legal(req_write, req_funct3) ||
                   ((req_addr[2:0] & ((3'd1 << req_funct3[1:0]) - 3'd1)) != 3'd0);

  assign lane_data = mem_rdata >> {off_p0, 3'b000};

  // Gated by RESET_N so a reset mid-access releases the pipeline at once.
  assign stall = RESET_N & ((state == BUSY) | ((state == IDLE) & req_valid));

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tcnt;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      f3_p0     <= '0;
      off_p0    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      fault     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef LSU_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      case (state)
        // p0: request capture
        IDLE: begin
          if (req_valid) begin
            if (bad_req) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              fault     <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= BUSY;
              mem_req   <= 1'b1;
              mem_we    <= req_write;
              mem_be    <= req_write ? lane_mask(req_funct3[1:0], req_addr[OFFW-1:0]) : '1;
              mem_addr  <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
              mem_wdata <= replicate(req_wdata, req_funct3[1:0]);
              f3_p0     <= req_funct3;
              off_p0    <= req_addr[OFFW-1:0];
`ifdef LSU_TIMEOUT_EN
              tcnt      <= '0;
`endif
            end
          end
        end
        // p1: bus wait; ack wins over an expiring timeout
        BUSY: begin
          if (mem_ack) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            fault     <= 1'b0;
            rsp_rdata <= mem_we ? '0 : extend(lane_data, f3_p0);
          end
`ifdef LSU_TIMEOUT_EN
          else if (tcnt == CW'(TIMEOUT - 1)) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            fault     <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        // p2: response pulse, pipeline advances on this edge
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          fault     <= 1'b0;
          rsp_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/rvi_lsu.md
# rvi_lsu

Parametrised load/store unit for the RVI core's MEM stage, replacing the raw single-cycle `daddr`/`ddata_w`/`MemRead`/`MemWrite` data-memory port with a variable-latency request/acknowledge bus. It handles:

- byte-lane steering for byte, halfword and word (and doubleword on XLEN=64) accesses;
- load sign/zero extension;
- misaligned-access and illegal-size detection;
- an optional bus timeout.

While an access is outstanding it asserts `stall` to freeze the pipeline.

## Interface
- `XLEN`, 32, data width; legal values 32 or 64.
- `ADDR_W`, 32, byte-address width.
- `TIMEOUT`, 15, maximum BUSY cycles without `mem_ack` before fault. Only used with `LSU_TIMEOUT_EN`.

- `CLK` in 1: clock, rising edge.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: MEM-stage instruction is a load or store.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3 size/sign code.
- `req_addr` in ADDR_W: byte address (ALU result).
- `req_wdata` in XLEN: store data (rs2).
- `stall` out 1: hold pipeline registers.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out XLEN: extended load data; 0 for stores and faults.
- `fault` out 1: one-cycle pulse, coincident with `rsp_valid`.
- `mem_req` out 1: bus request, held until acknowledged.
- `mem_we` out 1: bus write enable.
- `mem_be` out XLEN/8: byte enables; all 1s for loads.
- `mem_addr` out ADDR_W: address aligned to an XLEN/8-byte boundary.
- `mem_wdata` out XLEN: lane-replicated store data.
- `mem_ack` in 1: bus completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in XLEN: bus read data.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Reset value of every output and register is 0; state resets to IDLE.
- **IDLE:**
  - `stall` = `req_valid`.
  - A legal, aligned request is latched on the clock edge. The FSM moves to BUSY with `mem_req`=1 and `mem_addr`/`mem_be`/`mem_wdata`/`mem_we` registered.
  - A misaligned or illegal request goes to DONE with the fault flag set. No bus request is issued.
- **BUSY:**
  - `stall` = 1 and `mem_req` = 1.
  - When `mem_ack`=1: drop `mem_req`, capture and extend load data, move to DONE.
- **DONE:**
  - `stall` = 0, `rsp_valid` = 1, `fault` = fault flag.
  - Next state is always IDLE. The pipeline advances on this edge, so the same request is never re-accepted.
- **Size legality:**
  - funct3 000/001/010/100/101 are always legal.
  - 011 (LD/SD) and 110 (LWU) are legal only when XLEN=64.
  - 111 is illegal.
  - Stores legal only with 000–011.
- **Alignment:** access size in bytes = 2^funct3[1:0]. The request is misaligned when `req_addr` mod size ≠ 0.
- **Byte offset:** `off` = `req_addr[log2(XLEN/8)-1:0]`.
  - `mem_be` = ((1<<size)-1) << `off`.
  - `mem_wdata` = low `size` bytes of `req_wdata` replicated across the bus.
- **Loads:** extract the `size` bytes at `off` from `mem_rdata`.
  - funct3[2]=0: sign-extend to XLEN.
  - funct3[2]=1: zero-extend.

## Timing
- Zero-wait access: request presented in cycle 0, `mem_req` high in cycle 1, `mem_ack` in cycle 1, `rsp_valid` in cycle 2. `stall` is high in cycles 0–1.
- Each wait cycle adds one cycle to the above.
- Fault path: `stall` high for 1 cycle; `rsp_valid`/`fault` in cycle 1.
- `mem_*` outputs are stable for the whole of BUSY.
- `mem_ack` is ignored outside BUSY.
- `req_*` inputs are sampled only in IDLE.
- Reset asserted mid-access:
  - `mem_req`, `stall` and all other outputs go to 0 immediately.
  - No response is produced for the aborted access.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A cycle counter runs in BUSY.
  - After TIMEOUT consecutive cycles without `mem_ack`: drop `mem_req`, enter DONE with `fault`=1 and `rsp_rdata`=0.
  - An ack arriving in the same cycle the counter expires wins: normal completion.
- `LSU_TIMEOUT_EN` not defined: no counter; BUSY waits indefinitely for `mem_ack`.

## Test plan
- LW, `req_addr`=0x100, zero-wait ack, `mem_rdata`=0xDEADBEEF -> `mem_addr`=0x100, `mem_be`=0xF, `rsp_valid` in cycle 2, `rsp_rdata`=0xDEADBEEF, `fault`=0.
- LB / LBU, `req_addr`=0x103, `mem_rdata`=0x80112233 -> `rsp_rdata`=0xFFFFFF80 / 0x00000080.
- SH, `req_addr`=0x102, `req_wdata`=0x0000ABCD, ack after 3 wait cycles -> `mem_addr`=0x100, `mem_be`=0b1100, `mem_wdata`=0xABCDABCD, `mem_we`=1, `stall` high 5 cycles, `rsp_valid` in cycle 5.
- LW, `req_addr`=0x101 (and separately funct3=111) -> no `mem_req`, `stall` for 1 cycle, `rsp_valid`=`fault`=1 in cycle 1.
- With `LSU_TIMEOUT_EN`, TIMEOUT=4, ack never asserted -> `mem_req` high exactly 4 cycles, then `rsp_valid`=`fault`=1, `rsp_rdata`=0.
- `RESET_N` pulsed low in the second BUSY cycle -> all outputs 0 asynchronously, no `rsp_valid`; the next request after release completes normally.
